// File: rtl/conv_pkg.sv
// conv_pkg: shared lane types, saturation bounds and per-lane requantization helpers.
// OFM_ROUND_EN selects round-half-up instead of floor for the right shift.
package conv_pkg;
  localparam int SUM_W = 32;
  localparam int Q_W = 8;
  typedef logic signed [SUM_W-1:0] sum_t;
  typedef logic signed [Q_W-1:0] q_t;
  typedef logic signed [SUM_W:0] ext_t;
  localparam ext_t Q_MAX = ext_t'(2 ** (Q_W - 1) - 1);
  localparam ext_t Q_MIN = -ext_t'(2 ** (Q_W - 1));

  // One extra bit keeps the rounding add from wrapping.
  function automatic ext_t rshift(input sum_t s, input logic [4:0] sh);
    ext_t x;
    x = ext_t'(s);
`ifdef OFM_ROUND_EN
    if (sh != 5'd0) x = x + (ext_t'(1) << (sh - 5'd1));
`endif
    return x >>> sh;
  endfunction

  function automatic q_t sat_relu(input ext_t t, input logic relu);
    return (relu && t < 0) ? q_t'(0) : t > Q_MAX ? q_t'(Q_MAX) : t < Q_MIN ? q_t'(Q_MIN) : q_t'(t);
  endfunction

  function automatic q_t requant(input sum_t s, input logic [4:0] sh, input logic relu);
    return sat_relu(rshift(s, sh), relu);
  endfunction
endpackage

// File: rtl/ofm_fifo.sv
// ofm_fifo: synchronous FIFO with full/empty flags, push accepted on full when popping, sync clear.
module ofm_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign rdata = empty ? '0 : mem[rp];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/ofm_requant_writer.sv
// ofm_requant_writer: requantizes per-column conv sums to 8 bits and streams packed words to OFM memory.
// Define OFM_ROUND_EN for round-half-up instead of floor on the right shift.
module ofm_requant_writer
  import conv_pkg::*;
#(
  parameter int COL = 8,
  parameter int SUM_WIDTH = SUM_W,
  parameter int Q_WIDTH = Q_W,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start_conv,
  input  logic [4:0]                          cfg_shift,
  input  logic                                cfg_relu,
  input  logic                                conv_done,
  input  logic [COL-1:0]                      sum_valid,
  input  logic signed [COL-1:0][SUM_WIDTH-1:0] sum,
  output logic                                ofm_valid,
  input  logic                                ofm_ready,
  output logic [COL*Q_WIDTH-1:0]              ofm_data,
  output logic [COL-1:0]                      ofm_mask,
  output logic [ADDR_WIDTH-1:0]               ofm_addr,
  output logic                                ofm_done,
  output logic                                ovf_err
);
  localparam int DW = COL * Q_WIDTH;
  logic [4:0] shift_r, shift;
  logic relu_r, relu;
  logic s1_v, s2_v, done_pend, full, empty, pop, idle;
  logic [COL-1:0] s1_mask, s2_mask;
  ext_t s1_t [COL];
  logic [DW-1:0] s2_data;
  logic [DW+COL-1:0] head;
  assign shift = start_conv ? cfg_shift : shift_r;
  assign relu = start_conv ? cfg_relu : relu_r;
  assign ofm_valid = ~empty;
  assign pop = ofm_valid & ofm_ready;
  assign idle = ~s1_v & ~s2_v & empty;
  assign {ofm_mask, ofm_data} = head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r <= '0;
      relu_r <= 1'b0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_mask <= '0;
      s2_mask <= '0;
      s2_data <= '0;
      for (int i = 0; i < COL; i++) s1_t[i] <= '0;
      done_pend <= 1'b0;
      ofm_done <= 1'b0;
      ofm_addr <= '0;
      ovf_err <= 1'b0;
    end else if (start_conv) begin
      shift_r <= cfg_shift;
      relu_r <= cfg_relu;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      done_pend <= 1'b0;
      ofm_done <= 1'b0;
      ofm_addr <= '0;
      ovf_err <= 1'b0;
    end else begin
      s1_v <= |sum_valid;
      if (|sum_valid) begin
        s1_mask <= sum_valid;
        for (int i = 0; i < COL; i++) s1_t[i] <= rshift(sum[i], shift);
      end
      s2_v <= s1_v;
      if (s1_v) begin
        s2_mask <= s1_mask;
        for (int i = 0; i < COL; i++) s2_data[i*Q_WIDTH +: Q_WIDTH] <= s1_mask[i] ? sat_relu(s1_t[i], relu) : '0;
      end
      if (pop) ofm_addr <= ofm_addr + 1'b1;
      if (s2_v & full & ~pop) ovf_err <= 1'b1;
      ofm_done <= done_pend & idle;
      done_pend <= conv_done | (done_pend & ~idle);
    end
  end

  ofm_fifo #(.WIDTH(DW + COL), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clr(start_conv),
    .push(s2_v),
    .pop(pop),
    .wdata({s2_mask, s2_data}),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_ofm_requant_writer.sv
// tb_ofm_requant_writer: directed self-checking bench for ofm_requant_writer.
module tb_ofm_requant_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_conv = 1'b0;
  logic [4:0] cfg_shift = '0;
  logic cfg_relu = 1'b0;
  logic conv_done = 1'b0;
  logic [7:0] sum_valid = '0;
  logic signed [7:0][31:0] sum = '0;
  logic ofm_valid, ofm_ready, ofm_done, ovf_err;
  logic [63:0] ofm_data;
  logic [7:0] ofm_mask;
  logic [11:0] ofm_addr;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ofm_requant_writer dut (
    .clk(clk),
    .rst(rst),
    .start_conv(start_conv),
    .cfg_shift(cfg_shift),
    .cfg_relu(cfg_relu),
    .conv_done(conv_done),
    .sum_valid(sum_valid),
    .sum(sum),
    .ofm_valid(ofm_valid),
    .ofm_ready(ofm_ready),
    .ofm_data(ofm_data),
    .ofm_mask(ofm_mask),
    .ofm_addr(ofm_addr),
    .ofm_done(ofm_done),
    .ovf_err(ovf_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scrambles cfg after the pulse so later beats must use the latched copy.
  task automatic start(input logic [4:0] sh, input logic rl);
    cfg_shift = sh;
    cfg_relu = rl;
    start_conv = 1'b1;
    tick();
    start_conv = 1'b0;
    cfg_shift = 5'd31;
    cfg_relu = ~rl;
  endtask

  task automatic beat(input logic [7:0] v);
    sum_valid = v;
    tick();
    sum_valid = '0;
  endtask

  initial begin
    logic [7:0] exp_r;
    int npop, seen;
`ifdef OFM_ROUND_EN
    exp_r = 8'd63;
`else
    exp_r = 8'd62;
`endif
    ofm_ready = 1'b0;
    repeat (2) tick();
    check("rst_valid", ofm_valid, 0);
    check("rst_data", ofm_data, 0);
    check("rst_mask", ofm_mask, 0);
    check("rst_addr", ofm_addr, 0);
    check("rst_done", ofm_done, 0);
    check("rst_ovf", ovf_err, 0);
    rst = 1'b0;
    tick();

    start(5'd4, 1'b0);
    sum[0] = 1000;
    beat(8'h01);
    check("lat_n1", ofm_valid, 0);
    tick();
    check("lat_n2", ofm_valid, 0);
    tick();
    check("lat_n3", ofm_valid, 1);
    check("shift4", ofm_data[7:0], exp_r);
    check("shift4_mask", ofm_mask, 8'h01);
    check("shift4_addr", ofm_addr, 0);
    ofm_ready = 1'b1;
    tick();
    ofm_ready = 1'b0;
    check("pop_valid", ofm_valid, 0);
    check("pop_addr", ofm_addr, 1);
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    check("done_early", ofm_done, 0);
    tick();
    check("done_pulse", ofm_done, 1);
    tick();
    check("done_clear", ofm_done, 0);

    start(5'd0, 1'b0);
    sum = '0;
    sum[0] = 5000;
    sum[1] = -300;
    sum[2] = -300;
    sum[3] = 127;
    beat(8'h0F);
    tick();
    tick();
    check("sat", ofm_data, 64'h7F80807F);
    check("sat_mask", ofm_mask, 8'h0F);
    start(5'd0, 1'b1);
    beat(8'h0F);
    tick();
    tick();
    check("relu", ofm_data, 64'h7F00007F);

    start(5'd0, 1'b0);
    for (int i = 0; i < 8; i++) sum[i] = i + 1;
    beat(8'h05);
    tick();
    tick();
    check("part_data", ofm_data, 64'h0000000000030001);
    check("part_mask", ofm_mask, 8'h05);

    start(5'd0, 1'b0);
    sum = '0;
    for (int k = 0; k < 8; k++) begin
      sum[0] = k;
      conv_done = (k == 7);
      beat(8'h01);
    end
    conv_done = 1'b0;
    tick();
    tick();
    check("ovf_set", ovf_err, 1);
    check("ovf_nodone", ofm_done, 0);
    check("ovf_valid", ofm_valid, 1);
    ofm_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("ovf_addr", ofm_addr, k);
      check("ovf_data", ofm_data, k);
      tick();
    end
    check("ovf_drained", ofm_valid, 0);
    seen = 0;
    for (int k = 0; k < 6 && seen == 0; k++) begin
      if (ofm_done) seen = 1;
      else tick();
    end
    check("ovf_done", seen, 1);
    ofm_ready = 1'b0;

    start(5'd0, 1'b0);
    npop = 0;
    for (int c = 0; c < 20; c++) begin
      sum[0] = c;
      sum_valid = (c < 12) ? 8'h01 : 8'h00;
      ofm_ready = (c >= 6);
      if (ofm_valid && ofm_ready) begin
        check("stream_addr", ofm_addr, npop);
        check("stream_data", ofm_data, npop);
        npop++;
      end
      tick();
    end
    sum_valid = '0;
    ofm_ready = 1'b0;
    check("stream_cnt", npop, 12);
    check("stream_ovf", ovf_err, 0);

    for (int k = 0; k < 6; k++) begin
      sum[0] = k;
      conv_done = (k == 5);
      beat(8'h01);
    end
    conv_done = 1'b0;
    tick();
    tick();
    check("mid_ovf", ovf_err, 1);
    check("mid_addr", ofm_addr, 12);
    check("mid_valid", ofm_valid, 1);
    start(5'd0, 1'b0);
    check("clr_valid", ofm_valid, 0);
    check("clr_addr", ofm_addr, 0);
    check("clr_ovf", ovf_err, 0);
    check("clr_data", ofm_data, 0);
    seen = 0;
    repeat (6) begin
      if (ofm_done || ofm_valid) seen++;
      tick();
    end
    check("clr_quiet", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
